// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg : RV32I opcode/funct constants, ALU-op enum and decode types
// Rev 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_opimm  = 7'b0010011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;

  localparam logic [2:0] c_f3_beq  = 3'b000;
  localparam logic [2:0] c_f3_bne  = 3'b001;
  localparam logic [2:0] c_f3_blt  = 3'b100;
  localparam logic [2:0] c_f3_bge  = 3'b101;
  localparam logic [2:0] c_f3_bltu = 3'b110;
  localparam logic [2:0] c_f3_bgeu = 3'b111;

  localparam logic [2:0] c_f3_lw = 3'b010;
  localparam logic [2:0] c_f3_sw = 3'b010;

  localparam logic [2:0] c_f3_add  = 3'b000;
  localparam logic [2:0] c_f3_sll  = 3'b001;
  localparam logic [2:0] c_f3_slt  = 3'b010;
  localparam logic [2:0] c_f3_sltu = 3'b011;
  localparam logic [2:0] c_f3_xor  = 3'b100;
  localparam logic [2:0] c_f3_srl  = 3'b101;
  localparam logic [2:0] c_f3_or   = 3'b110;
  localparam logic [2:0] c_f3_and  = 3'b111;

  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_ALU   = 3'd0,
    WB_IMM   = 3'd1,
    WB_PCIMM = 3'd2,
    WB_PC4   = 3'd3,
    WB_MEM   = 3'd4
  } wb_sel_e;

  typedef struct packed {
    logic    reg_we;
    logic    mem_we;
    logic    use_imm;
    logic    is_branch;
    logic    is_jal;
    logic    is_jalr;
    alu_op_e alu_op;
    wb_sel_e wb_sel;
  } ctrl_t;

  // ALU operation selected by funct3 when funct7 carries no alternate bit
  function automatic alu_op_e alu_base_op(input logic [2:0] f3);
    alu_op_e r;
    r = ALU_ADD;
    case (f3)
      c_f3_add:  r = ALU_ADD;
      c_f3_sll:  r = ALU_SLL;
      c_f3_slt:  r = ALU_SLT;
      c_f3_sltu: r = ALU_SLTU;
      c_f3_xor:  r = ALU_XOR;
      c_f3_srl:  r = ALU_SRL;
      c_f3_or:   r = ALU_OR;
      c_f3_and:  r = ALU_AND;
      default:   r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_memory.sv
// ============================================================================
// memory : word-addressed 32-bit RAM, asynchronous read, synchronous write
// Rev 1.0
// ============================================================================
`default_nettype none

module memory #(
  parameter int WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);

  localparam int c_aw = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0]     mem [WORDS];
  logic [c_aw-1:0] w_idx;
  logic            w_unused;

  // Byte address in, word index out; depth need not be a power of two
  assign w_idx    = c_aw'({2'b00, i_addr[31:2]} % WORDS);
  assign w_unused = &{1'b0, i_addr[1:0]};
  assign o_rdata  = mem[w_idx];

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      mem[w_idx] <= i_wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/core.sv
// ============================================================================
// core : single-cycle RV32I integer core (one instruction retired per clock)
// Rev 1.0
// ============================================================================
`default_nettype none

module core
  import core_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk_i,
  input logic rst_i
);

  logic [31:0] pc;
  logic [31:0] regs [32];

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  ctrl_t       w_ctrl;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_op_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu;
  logic        w_taken;
  logic [31:0] w_ls_addr;
  logic [31:0] w_load_data;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic [31:0] w_wb_data;
  logic        w_dmem_we;

  memory #(.WORDS(IMEM_WORDS)) i_mem (
    .clk_i   (clk_i),
    .i_we    (1'b0),
    .i_addr  (pc),
    .i_wdata (32'h0000_0000),
    .o_rdata (w_instr)
  );

  // Reset suppresses the store so an aborted instruction leaves memory intact
  assign w_dmem_we = w_ctrl.mem_we & ~rst_i;

  memory #(.WORDS(DMEM_WORDS)) d_mem (
    .clk_i   (clk_i),
    .i_we    (w_dmem_we),
    .i_addr  (w_ls_addr),
    .i_wdata (w_rs2_val),
    .o_rdata (w_load_data)
  );

  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_f3     = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_f7     = w_instr[31:25];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                    w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'h000};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                    w_instr[30:21], 1'b0};

  // Decoder: anything not recognised leaves every enable low, i.e. a NOP
  always_comb begin
    w_ctrl        = '0;
    w_ctrl.alu_op = ALU_ADD;
    w_ctrl.wb_sel = WB_ALU;
    case (w_opcode)
      c_opc_lui: begin
        w_ctrl.reg_we = 1'b1;
        w_ctrl.wb_sel = WB_IMM;
      end
      c_opc_auipc: begin
        w_ctrl.reg_we = 1'b1;
        w_ctrl.wb_sel = WB_PCIMM;
      end
      c_opc_jal: begin
        w_ctrl.reg_we = 1'b1;
        w_ctrl.wb_sel = WB_PC4;
        w_ctrl.is_jal = 1'b1;
      end
      c_opc_jalr: begin
        if (w_f3 == 3'b000) begin
          w_ctrl.reg_we  = 1'b1;
          w_ctrl.wb_sel  = WB_PC4;
          w_ctrl.is_jalr = 1'b1;
        end
      end
      c_opc_branch: begin
        w_ctrl.is_branch = (w_f3 != 3'b010) && (w_f3 != 3'b011);
      end
      c_opc_load: begin
        if (w_f3 == c_f3_lw) begin
          w_ctrl.reg_we = 1'b1;
          w_ctrl.wb_sel = WB_MEM;
        end
      end
      c_opc_store: begin
        w_ctrl.mem_we = (w_f3 == c_f3_sw);
      end
      c_opc_opimm: begin
        w_ctrl.use_imm = 1'b1;
        w_ctrl.alu_op  = alu_base_op(w_f3);
        if (w_f3 == c_f3_sll) begin
          w_ctrl.reg_we = (w_f7 == c_f7_base);
        end else if (w_f3 == c_f3_srl) begin
          w_ctrl.reg_we = (w_f7 == c_f7_base) || (w_f7 == c_f7_alt);
          if (w_f7 == c_f7_alt) w_ctrl.alu_op = ALU_SRA;
        end else begin
          w_ctrl.reg_we = 1'b1;
        end
      end
      c_opc_op: begin
        w_ctrl.alu_op = alu_base_op(w_f3);
        if (w_f7 == c_f7_base) begin
          w_ctrl.reg_we = 1'b1;
        end else if (w_f7 == c_f7_alt && w_f3 == c_f3_add) begin
          w_ctrl.reg_we = 1'b1;
          w_ctrl.alu_op = ALU_SUB;
        end else if (w_f7 == c_f7_alt && w_f3 == c_f3_srl) begin
          w_ctrl.reg_we = 1'b1;
          w_ctrl.alu_op = ALU_SRA;
        end
      end
      default: ;
    endcase
  end

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'h0000_0000 : regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'h0000_0000 : regs[w_rs2];
  assign w_op_b    = w_ctrl.use_imm ? w_imm_i : w_rs2_val;
  assign w_shamt   = w_op_b[4:0];

  always_comb begin
    w_alu = 32'h0000_0000;
    case (w_ctrl.alu_op)
      ALU_ADD:  w_alu = w_rs1_val + w_op_b;
      ALU_SUB:  w_alu = w_rs1_val - w_op_b;
      ALU_SLL:  w_alu = w_rs1_val << w_shamt;
      ALU_SLT:  w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_op_b)};
      ALU_SLTU: w_alu = {31'd0, w_rs1_val < w_op_b};
      ALU_XOR:  w_alu = w_rs1_val ^ w_op_b;
      ALU_SRL:  w_alu = w_rs1_val >> w_shamt;
      ALU_SRA:  w_alu = $signed(w_rs1_val) >>> w_shamt;
      ALU_OR:   w_alu = w_rs1_val | w_op_b;
      ALU_AND:  w_alu = w_rs1_val & w_op_b;
      default:  w_alu = 32'h0000_0000;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      c_f3_beq:  w_taken = (w_rs1_val == w_rs2_val);
      c_f3_bne:  w_taken = (w_rs1_val != w_rs2_val);
      c_f3_blt:  w_taken = ($signed(w_rs1_val) < $signed(w_rs2_val));
      c_f3_bge:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      c_f3_bltu: w_taken = (w_rs1_val < w_rs2_val);
      c_f3_bgeu: w_taken = (w_rs1_val >= w_rs2_val);
      default:   w_taken = 1'b0;
    endcase
  end

  assign w_ls_addr  = w_rs1_val + (w_ctrl.mem_we ? w_imm_s : w_imm_i);
  assign w_pc_plus4 = pc + 32'd4;

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_ctrl.is_jal) begin
      w_pc_next = pc + w_imm_j;
    end else if (w_ctrl.is_jalr) begin
      w_pc_next = (w_rs1_val + w_imm_i) & 32'hFFFF_FFFE;
    end else if (w_ctrl.is_branch && w_taken) begin
      w_pc_next = pc + w_imm_b;
    end
  end

  always_comb begin
    w_wb_data = w_alu;
    case (w_ctrl.wb_sel)
      WB_ALU:   w_wb_data = w_alu;
      WB_IMM:   w_wb_data = w_imm_u;
      WB_PCIMM: w_wb_data = pc + w_imm_u;
      WB_PC4:   w_wb_data = w_pc_plus4;
      WB_MEM:   w_wb_data = w_load_data;
      default:  w_wb_data = w_alu;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc <= RESET_PC;
    end else begin
      pc <= w_pc_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0000_0000;
      end
    end else if (w_ctrl.reg_we && (w_rd != 5'd0)) begin
      regs[w_rd] <= w_wb_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core.sv
// ============================================================================
// tb_core : directed and random-program bench for core against an ISA model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_core;

  localparam int IW = 64;
  localparam int DW = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  core #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .RESET_PC(32'h0000_0000)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_imem [IW];
  logic [31:0] m_dmem [DW];
  logic [31:0] p      [IW];
  logic [31:0] dinit  [DW];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd, input logic [6:0] op);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    return {imm[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input int rs2, input int rs1);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'h6f};
  endfunction

  function automatic int didx(input logic [31:0] ad);
    return int'({2'b00, ad[31:2]} % DW);
  endfunction

  // Instruction-set reference: one architectural step from the ISA rules
  task automatic m_step(output int rd_o);
    logic [31:0] w, a, b, x, ii, is, ib, iu, ij, npc, res;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic        wr, take, alt, legal;
    int          rd, r1, r2, sh;
    w  = m_imem[int'({2'b00, m_pc[31:2]} % IW)];
    op = w[6:0]; rd = int'(w[11:7]); f3 = w[14:12];
    r1 = int'(w[19:15]); r2 = int'(w[24:20]); f7 = w[31:25];
    a  = m_regs[r1]; b = m_regs[r2];
    ii = {{20{w[31]}}, w[31:20]};
    is = {{20{w[31]}}, w[31:25], w[11:7]};
    ib = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    iu = {w[31:12], 12'h000};
    ij = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    npc = m_pc + 32'd4; wr = 1'b0; res = 32'h0; take = 1'b0;
    case (op)
      7'h37: begin wr = 1'b1; res = iu; end
      7'h17: begin wr = 1'b1; res = m_pc + iu; end
      7'h6f: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + ij; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; res = m_pc + 32'd4; npc = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) < $signed(b));
          3'd5: take = ($signed(a) >= $signed(b));
          3'd6: take = (a < b);
          3'd7: take = (a >= b);
          default: take = 1'b0;
        endcase
        if (take) npc = m_pc + ib;
      end
      7'h03: if (f3 == 3'd2) begin wr = 1'b1; res = m_dmem[didx(a + ii)]; end
      7'h23: if (f3 == 3'd2) m_dmem[didx(a + is)] = b;
      7'h13, 7'h33: begin
        x   = (op == 7'h13) ? ii : b;
        sh  = int'(x[4:0]);
        alt = (f7 == 7'h20);
        if (op == 7'h33) legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
        else if (f3 == 3'd1) legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || alt;
        else legal = 1'b1;
        case (f3)
          3'd0: res = (op == 7'h33 && alt) ? a - x : a + x;
          3'd1: res = a << sh;
          3'd2: res = ($signed(a) < $signed(x)) ? 32'd1 : 32'd0;
          3'd3: res = (a < x) ? 32'd1 : 32'd0;
          3'd4: res = a ^ x;
          3'd5: res = alt ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: res = a | x;
          default: res = a & x;
        endcase
        wr = legal;
      end
      default: ;
    endcase
    if (wr && rd != 0) m_regs[rd] = res;
    m_pc = npc;
    rd_o = rd;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < IW; i++) p[i] = NOP;
    for (int i = 0; i < DW; i++) dinit[i] = $urandom;
  endtask

  // Pulse reset between edges, check the asynchronous clear, then load memories
  task automatic start_program();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_val("rst_pc", dut.pc, 32'h0);
    for (int i = 1; i < 32; i++) check_val($sformatf("rst_x%0d", i), dut.regs[i], 32'h0);
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    for (int i = 0; i < IW; i++) begin m_imem[i] = p[i]; dut.i_mem.mem[i] = p[i]; end
    for (int i = 0; i < DW; i++) begin m_dmem[i] = dinit[i]; dut.d_mem.mem[i] = dinit[i]; end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    int rd;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_i);
      m_step(rd);
      #1;
      check_val("pc", dut.pc, m_pc);
      check_val($sformatf("x%0d", rd), dut.regs[rd], m_regs[rd]);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) check_val($sformatf("%s_x%0d", tag, i), dut.regs[i], m_regs[i]);
    for (int i = 0; i < DW; i++) check_val($sformatf("%s_d%0d", tag, i), dut.d_mem.mem[i], m_dmem[i]);
  endtask

  function automatic logic [31:0] rand_instr();
    int rd, r1, r2, k;
    logic [31:0] imm;
    logic [2:0]  f3;
    rd = $urandom_range(0, 15); r1 = $urandom_range(0, 15); r2 = $urandom_range(0, 15);
    f3 = 3'($urandom_range(0, 7)); imm = $urandom;
    k  = $urandom_range(0, 15);
    case (k)
      0: return enc_r(($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, r2, r1, f3, rd, 7'h33);
      1: return enc_i(imm, r1, f3, rd, 7'h13);
      2: return enc_i({20'h0, ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00, imm[4:0]},
                      r1, ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5, rd, 7'h13);
      3: return {imm[19:0], 5'(rd), 7'h37};
      4: return {imm[19:0], 5'(rd), 7'h17};
      5: return enc_j(32'(int'($urandom_range(0, 31)) - 16) << 2, rd);
      6: return enc_i(imm, r1, 3'd0, rd, 7'h67);
      7, 8: begin
        imm = 32'(int'($urandom_range(0, 15)) - 8) << 2;
        if (imm == 32'h0) imm = 32'd8;
        return enc_b(imm, r2, r1, f3);
      end
      9, 10: return enc_i(imm, r1, 3'd2, rd, 7'h03);
      11, 12: return enc_s(imm, r2, r1);
      13: case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0073;
            2: return 32'h0010_0073;
            3: return 32'h0000_000F;
            4: return enc_i(imm, r1, 3'd0, rd, 7'h03);
            5: return {7'h0, 5'(r2), 5'(r1), 3'd0, 5'h4, 7'h23};
            default: return 32'h3401_1073;
          endcase
      default: return enc_i(32'(int'($urandom_range(0, 64)) - 32), r1, 3'd0, rd, 7'h13);
    endcase
  endfunction

  initial begin
    // Arithmetic sequence
    clear_prog();
    p[0] = enc_i(32'd5, 0, 3'd0, 1, 7'h13);
    p[1] = enc_i(-32'sd3, 0, 3'd0, 2, 7'h13);
    p[2] = enc_r(7'h00, 2, 1, 3'd0, 3, 7'h33);
    p[3] = enc_r(7'h20, 1, 2, 3'd0, 4, 7'h33);
    p[4] = enc_i({20'h0, 7'h20, 5'd1}, 2, 3'd5, 5, 7'h13);
    start_program();
    run_cycles(5);
    check_val("alu_x3", dut.regs[3], 32'h0000_0002);
    check_val("alu_x4", dut.regs[4], 32'hFFFF_FFF8);
    check_val("alu_x5", dut.regs[5], 32'hFFFF_FFFE);

    // Load then store
    clear_prog();
    dinit[4] = 32'h1234_5678;
    p[0] = enc_i(32'd16, 0, 3'd2, 6, 7'h03);
    p[1] = enc_s(32'd20, 6, 0);
    start_program();
    run_cycles(2);
    check_val("mem_x6", dut.regs[6], 32'h1234_5678);
    check_val("mem_d5", dut.d_mem.mem[5], 32'h1234_5678);
    check_all("mem");

    // Counted loop then JAL at 0x20
    clear_prog();
    p[0] = enc_i(32'd3, 0, 3'd0, 7, 7'h13);
    p[1] = enc_i(32'd1, 1, 3'd0, 1, 7'h13);
    p[2] = enc_b(-32'sd4, 7, 1, 3'd1);
    p[8] = enc_j(32'd8, 1);
    start_program();
    run_cycles(7);
    check_val("loop_x1", dut.regs[1], 32'd3);
    check_val("loop_pc", dut.pc, 32'h0000_000C);
    run_cycles(6);
    check_val("jal_x1", dut.regs[1], 32'h0000_0024);
    check_val("jal_pc", dut.pc, 32'h0000_0028);

    // x0 write discard, LUI, AUIPC at 0x40
    clear_prog();
    p[14] = enc_i(32'd7, 0, 3'd0, 0, 7'h13);
    p[15] = {20'hABCDE, 5'd8, 7'h37};
    p[16] = {20'h00001, 5'd9, 7'h17};
    start_program();
    run_cycles(17);
    check_val("x0", dut.regs[0], 32'h0);
    check_val("lui_x8", dut.regs[8], 32'hABCD_E000);
    check_val("auipc_x9", dut.regs[9], 32'h0000_1040);

    // ECALL and all-zero word behave as NOPs
    clear_prog();
    p[0] = 32'h0000_0073;
    p[1] = 32'h0000_0000;
    start_program();
    run_cycles(1);
    check_val("ecall_pc", dut.pc, 32'h0000_0004);
    run_cycles(1);
    check_val("zero_pc", dut.pc, 32'h0000_0008);
    check_all("illegal");

    // Random programs, each ended by a mid-run reset at the next start
    for (int t = 0; t < 6; t++) begin
      clear_prog();
      for (int i = 0; i < IW; i++) p[i] = rand_instr();
      start_program();
      run_cycles(300);
      check_all($sformatf("rnd%0d", t));
    end
    clear_prog();
    start_program();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core.md
CORE -- requirements
Module: core

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 1024, meaning data memory depth in 32-bit words.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have no other ports; state is observable only through hierarchy (i_mem.mem, d_mem.mem, regs, pc).

Function
REQ-007 SHALL implement a single-cycle RV32I integer core that retires one instruction per rising clk_i edge while rst_i is low.
REQ-008 SHALL support LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
REQ-009 SHALL treat every other encoding (FENCE, ECALL, EBREAK, CSR, byte/half loads/stores, illegal) as a NOP: PC+4, no register or memory write.
REQ-010 SHALL fetch combinationally from i_mem.mem[pc[31:2] mod IMEM_WORDS]; pc[1:0] ignored.
REQ-011 SHALL compute next PC as PC+4, PC+imm for taken branch/JAL, or (rs1+imm) & ~1 for JALR; all arithmetic 32-bit modulo 2^32 with wrap-around.
REQ-012 SHALL write PC+4 to rd for JAL/JALR.
REQ-013 SHALL read data memory combinationally for LW at address (rs1+imm)[31:2] mod DMEM_WORDS; low two address bits ignored.
REQ-014 SHALL write rs2 to d_mem.mem at the same word index on the rising edge for SW.
REQ-015 SHALL hold a 32x32 register file named regs with two combinational read ports and one write port written on the rising edge.
REQ-016 SHALL hardwire x0 to zero: reads return 0, writes discarded.
REQ-017 SHALL, when an instruction reads a register it also writes, use the pre-edge value (single-cycle, no forwarding needed).
REQ-018 SHALL use shift amount rs2[4:0]/shamt[4:0]; SRA/SRAI sign-extend; SLT signed, SLTU unsigned.
REQ-019 SHALL sign-extend all I/S/B/J immediates; U-type immediates fill [31:12] with [11:0] zero.

Reset
REQ-020 SHALL, while rst_i is high, asynchronously force pc to RESET_PC and all regs to 0, suppressing memory writes.
REQ-021 SHALL NOT clear i_mem or d_mem contents on reset (preloaded externally by $readmemh into mem arrays).
REQ-022 SHALL resume execution from RESET_PC on the first rising edge after rst_i falls; reset asserted mid-program aborts the current instruction with no write.

Structure
REQ-023 SHALL place opcode/funct3/funct7 constants and the ALU-op enum in a shared package core_pkg.
REQ-024 SHALL use one sub-module, memory (parameter WORDS; 32-bit array named mem; async read, sync write enable), instantiated as i_mem (write disabled) and d_mem.
REQ-025 SHALL keep decoder, ALU, branch compare and register file inside core.

Verification
REQ-026 Reset: rst_i pulsed high mid-run -> pc=0 and regs[1..31]=0 immediately, before any clock edge.
REQ-027 ALU: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1; SRAI x5,x2,1 -> x3=2, x4=0xFFFF_FFF8, x5=0xFFFF_FFFE.
REQ-028 Memory: d_mem.mem[4]=0x1234_5678; LW x6,16(x0); SW x6,20(x0) -> x6=0x1234_5678, d_mem.mem[5]=0x1234_5678.
REQ-029 Branch/jump: loop ADDI x1,x1,1; BNE x1,x7,-4 with x7=3 -> exits with x1=3; JAL x1,+8 at pc 0x20 -> x1=0x24, pc=0x28.
REQ-030 x0/LUI: ADDI x0,x0,7; LUI x8,0xABCDE; AUIPC x9,1 at pc 0x40 -> x0=0, x8=0xABCD_E000, x9=0x1040.
REQ-031 Illegal: ECALL and word 0x0000_0000 -> pc advances by 4, no register or memory change.
